// File: rtl/strobseq.sv
// strobseq: clocked microcycle sequencer producing strob1/strob2/got phases,
// with bus-wait timeout alarm, single-step and front-panel strobe modes.
module strobseq #(
   parameter int NCLS = 5,
   parameter int TW = 4,
   parameter logic [NCLS*TW-1:0] T1 = {5{4'd3}},
   parameter int STROB2_TICKS = 2,
   parameter int GOT_TICKS = 1,
   parameter int AW = 8,
   parameter int ALARM_TICKS = 200,
   localparam int CW = (NCLS > 1) ? $clog2(NCLS) : 1
) (
   input  logic          __clk,
   input  logic          clo_,
   input  logic [NCLS-1:0] ss,
   input  logic          busreq,
   input  logic          ok,
   input  logic          en,
   input  logic          mode,
   input  logic          step_,
   input  logic          strob_fp_,
   output logic          strob1,
   output logic          strob2,
   output logic          got,
   output logic          alarm,
   output logic          wait_bus,
   output logic          hold,
   output logic [CW-1:0] cls
);

   typedef enum logic [2:0] {
      RST, ST1, WB, ST2, GOT, HOLD, FP1
   } state_t;

   localparam logic [TW-1:0] S2_LD =
      (STROB2_TICKS > 1) ? TW'(STROB2_TICKS - 1) : '0;
   localparam logic [TW-1:0] GOT_LD =
      (GOT_TICKS > 1) ? TW'(GOT_TICKS - 1) : '0;
   localparam logic [AW-1:0] AL_LAST = AW'(ALARM_TICKS - 1);

   state_t state;
   state_t nxt;

   logic [TW-1:0] cnt;
   logic [AW-1:0] acnt;
   logic [CW-1:0] enc;
   logic [2:0]    stp_s;
   logic [2:0]    fp_s;
   logic          stp_eq;
   logic          fp_eq;
   logic          last;
   logic          reply;
   logic          timeout;

   // A zero length field still yields a one-tick strobe.
   function automatic logic [TW-1:0] t1_len(input logic [CW-1:0] idx);
      logic [TW-1:0] f;
      f = T1[int'(idx)*TW +: TW];
      return (f == '0) ? TW'(1) : f;
   endfunction

   assign last    = (cnt == '0);
   assign reply   = ok | en;
   assign timeout = (acnt == AL_LAST);

   always_comb begin
      enc = '0;
      for (int i = NCLS - 1; i >= 0; i--)
         if (ss[i]) enc = CW'(i);
   end

   always_ff @(posedge __clk or negedge clo_) begin
      if (!clo_) begin
         stp_s  <= 3'b111;
         fp_s   <= 3'b111;
         stp_eq <= 1'b0;
         fp_eq  <= 1'b0;
      end else begin
         stp_s  <= {stp_s[1:0], step_};
         fp_s   <= {fp_s[1:0], strob_fp_};
         stp_eq <= stp_s[2] & ~stp_s[1];
         fp_eq  <= fp_s[2] & ~fp_s[1];
      end
   end

   always_ff @(posedge __clk or negedge clo_) begin
      if (!clo_) state <= RST;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         RST:  nxt = ST1;
         ST1:  if (last) nxt = busreq ? WB : ST2;
         WB:   if (reply || timeout) nxt = ST2;
         ST2:  if (last) nxt = GOT;
         GOT:  if (last) nxt = mode ? HOLD : ST1;
         HOLD: begin
            if (stp_eq || !mode) nxt = ST1;
            else if (fp_eq)      nxt = FP1;
         end
         FP1:  if (last) nxt = HOLD;
         default: nxt = RST;
      endcase
   end

   always_ff @(posedge __clk or negedge clo_) begin
      if (!clo_) begin
         cnt   <= '0;
         acnt  <= '0;
         alarm <= 1'b0;
         cls   <= '0;
      end else begin
         alarm <= (state == WB) && !reply && timeout;
         if (state == WB && nxt == WB)
            acnt <= acnt + 1'b1;
         if (nxt != state) begin
            unique case (nxt)
               ST1: begin
                  cnt <= t1_len(enc) - TW'(1);
                  cls <= enc;
               end
               FP1: begin
                  cnt <= t1_len('0) - TW'(1);
                  cls <= '0;
               end
               WB:  acnt <= '0;
               ST2: cnt <= S2_LD;
               GOT: cnt <= GOT_LD;
               default: ;
            endcase
         end else if (!last) begin
            cnt <= cnt - TW'(1);
         end
      end
   end

   always_comb begin
      strob1   = 1'b0;
      strob2   = 1'b0;
      got      = 1'b0;
      wait_bus = 1'b0;
      hold     = 1'b0;
      unique case (state)
         ST1, FP1: strob1   = 1'b1;
         ST2:      strob2   = 1'b1;
         GOT:      got      = 1'b1;
         WB:       wait_bus = 1'b1;
         HOLD:     hold     = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: doc/strobseq.md
# strobseq

Synchronous, parametrised microcycle sequencer, the successor of the univibrator-based strobe generator in the P-X state-control unit. It produces the `strob1`, `strob2` and `got` phases of every CPU microcycle. The `strob1` length is selected per state class from a packed parameter vector. An optional system-bus wait phase has its own timeout alarm, and the block supports single-step and front-panel strobe modes. All timing is counted in `__clk` ticks, with no analog delays.

## Interface
Parameters:
- `NCLS`, 5: number of state classes (`ss` width).
- `TW`, 4: width of each tick count.
- `T1`, {5{4'd3}}: packed `NCLS*TW` vector; field i = `strob1` length of class i.
- `STROB2_TICKS`, 2: `strob2` length.
- `GOT_TICKS`, 1: `got` length.
- `AW`, 8: alarm counter width.
- `ALARM_TICKS`, 200: bus-wait timeout in ticks.

Ports (clock and reset first):
- `__clk` in 1: system clock.
- `clo_` in 1: general clear; reset is asynchronous and active-low.
- `ss` in NCLS: state-class request lines (ss11..ss15 equivalents).
- `busreq` in 1: current cycle uses the system bus.
- `ok` in 1: bus reply OK.
- `en` in 1: bus reply EN (no device / refused).
- `mode` in 1: 1 = step mode.
- `step_` in 1: step key, active-low, asynchronous.
- `strob_fp_` in 1: front-panel strobe key, active-low, asynchronous.
- `strob1` out 1: phase 1 strobe.
- `strob2` out 1: phase 2 strobe.
- `got` out 1: end of cycle; state registers clock on it.
- `alarm` out 1: one-tick bus-timeout pulse.
- `wait_bus` out 1: sequencer is in the bus-wait phase.
- `hold` out 1: stopped in step mode.
- `cls` out $clog2(NCLS): class latched for the current `strob1`.

## Operation
- States: RST, ST1, WB, ST2, GOT, HOLD, FP1.
- Outputs are decoded from the registered state:
  - `strob1` = ST1 or FP1
  - `strob2` = ST2
  - `got` = GOT
  - `wait_bus` = WB
  - `hold` = HOLD
- The `alarm` output is a separate register.
- Class select:
  - On entry to ST1, `cls` latches the lowest-index asserted `ss` bit.
  - If no bit is asserted, `cls` = 0.
  - The ST1 length is `T1[cls]`; a field value of 0 is treated as 1.
- RST → ST1 unconditionally on the first tick after `clo_` rises.
- ST1 → end of `strob1`:
  - If `busreq` is 1 on the last ST1 tick, go to WB; the alarm counter clears.
  - Otherwise go to ST2.
- WB, on each tick:
  - If `ok` or `en` is 1, go to ST2 on the next tick.
  - Otherwise the counter increments.
  - When the counter reaches ALARM_TICKS-1 with no reply, go to ST2 and set `alarm` for exactly one tick, coincident with the first ST2 tick.
  - A reply on the same tick as the timeout wins: no `alarm`.
- ST2 lasts STROB2_TICKS (0 → 1), then goes to GOT.
- GOT lasts GOT_TICKS (0 → 1). On its last tick:
  - `mode`=1: go to HOLD.
  - Otherwise: go to ST1.
- `step_` and `strob_fp_` pass through 2-FF synchronisers plus a falling-edge detector.
- HOLD exits:
  - A `step_` edge goes to ST1.
  - A `strob_fp_` edge goes to FP1.
  - `mode`=0 goes to ST1.
  - If edges coincide, `step_` wins.
- Edges arriving outside HOLD are discarded and never queued.
- FP1 is `strob1` only, for `T1[0]` ticks, then returns to HOLD. FP1 produces no `strob2` and no `got`; `cls` = 0.
- `busreq`, `ok` and `en` are synchronous to `__clk`. `ss` is sampled only on ST1 entry.

## Timing
- Reset values, while `clo_`=0:
  - Outputs `strob1`, `strob2`, `got`, `alarm`, `wait_bus`, `hold` = 0; `cls` = 0.
  - State = RST; counters = 0; synchronisers = 1.
- `clo_` asserted mid-cycle forces all of the above immediately, asynchronously.
- `strob1` is first high on the 2nd tick after `clo_` deassertion.
- Cycle length without bus = `T1[cls]` + STROB2_TICKS + GOT_TICKS ticks; no idle ticks between cycles.
- With bus: add the WB ticks. WB is at least 1 tick; it lasts n+1 ticks when the reply arrives on WB tick n (0-based). The maximum is ALARM_TICKS.
- Step latency: from `step_` falling to `strob1` high is 4 ticks (2 sync, 1 edge, 1 transition).
- `mode` is sampled only on the last GOT tick and in HOLD.

## Test plan
- Free run, default parameters, `ss`=5'b00100, `busreq`=0: `strob1` 3, `strob2` 2, `got` 1 tick, period 6, `cls`=2, with no gaps.
- Class priority and zero length: `T1` field 1 = 0, `ss`=5'b00110: `cls`=1, `strob1` 1 tick.
- Bus wait:
  - `busreq`=1, `ok` on WB tick 3: WB 4 ticks, `alarm`=0.
  - No reply: WB 200 ticks, `alarm` high exactly on the first ST2 tick.
  - `ok` on tick 199: no `alarm`.
- Step mode: `mode`=1 gives HOLD after `got`. `step_` pulse gives `strob1` 4 ticks later and exactly one cycle. A `strob_fp_` pulse in HOLD gives 3 `strob1` ticks, no `got`, and stays in HOLD. `step_` during ST2 is ignored.
- Reset mid-WB: `clo_` low gives all outputs 0 immediately. After release, `strob1` on the 2nd tick and the alarm counter restarts from 0.
